// File: rtl/pe_data_fifo.sv
// pe_data_fifo: first-word fall-through FIFO between a producer and a PE operand register.
// The head word sits on out_data with no read latency. It reads as zero while the FIFO is empty.
// in_ready and out_valid decode only from the registered pointers.
// Optional feature macro: PE_FIFO_COUNT_EN adds the occupancy port 'count'.
module pe_data_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PE_FIFO_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0] count
`endif
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Status decode from the registered pointers only (no path from in_valid/out_ready).
    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    end

    // Handshake qualification and output drive; the head word reads as zero while empty.
    always_comb begin
        in_ready  = !full;
        out_valid = !empty;
        push      = in_valid && !full;
        pop       = out_ready && !empty;
        out_data  = '0;
        if (!empty) begin
            out_data = mem[rd_ptr[AW-1:0]];
        end
    end

    // Pointer registers.
    // Reset clears them at once, so all held words are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write.
    // The array is deliberately not reset, because an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

`ifdef PE_FIFO_COUNT_EN
    // Occupancy is the modular pointer difference including the wrap bit.
    always_comb begin
        count = wr_ptr - rd_ptr;
    end
`endif

endmodule

// File: tb/tb_pe_data_fifo.sv
// Self-checking bench for pe_data_fifo (DEPTH=4, WIDTH=16).
// A queue model decides every push and pop from its own occupancy.
// Popped words are compared against the queue head.
module tb_pe_data_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
`ifdef PE_FIFO_COUNT_EN
    logic [$clog2(DEPTH):0] count;
`endif

    int checks   = 0;
    int failures = 0;
    logic [WIDTH-1:0] q[$];

    pe_data_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
`ifdef PE_FIFO_COUNT_EN
        ,
        .count    (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle of stimulus.
    // The model decides push/pop from its own occupancy and reports the word the DUT showed when a pop occurred.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r,
                         output logic popped, output logic [WIDTH-1:0] got,
                         output logic [WIDTH-1:0] exp);
        logic pushed;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        pushed = v && (q.size() < DEPTH);
        popped = r && (q.size() > 0);
        got    = out_data;
        exp    = '0;
        if (popped) exp = q.pop_front();
        if (pushed) q.push_back(d);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        q.delete();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 16'h0000) begin failures++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
`ifdef PE_FIFO_COUNT_EN
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
`endif
    endtask

    task automatic test_fill_full();
        logic p; logic [WIDTH-1:0] g, e;
        logic [WIDTH-1:0] words [4];
        words[0] = 16'h0011; words[1] = 16'h0022; words[2] = 16'h0033; words[3] = 16'h0044;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, words[i], 1'b0, p, g, e);
            checks++; if (out_data !== 16'h0011) begin failures++; $display("FAIL fill_head[%0d] got=%h exp=0011", i, out_data); end
            checks++; if (in_ready !== (i < 3)) begin failures++; $display("FAIL fill_in_ready[%0d] got=%b exp=%b", i, in_ready, (i < 3)); end
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL full_out_valid got=%b exp=1", out_valid); end
`ifdef PE_FIFO_COUNT_EN
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
`endif
    endtask

    task automatic test_full_refused();
        logic p; logic [WIDTH-1:0] g, e;
        cycle(1'b1, 16'hBEEF, 1'b1, p, g, e);
        checks++; if (g !== 16'h0011 || !p) begin failures++; $display("FAIL refused_pop got=%h exp=0011", g); end
        checks++; if (out_data !== 16'h0022) begin failures++; $display("FAIL refused_head got=%h exp=0022", out_data); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL refused_in_ready got=%b exp=1", in_ready); end
`ifdef PE_FIFO_COUNT_EN
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL refused_count got=%0d exp=3", count); end
`endif
        // Drain what is left.
        // 0xBEEF must never appear in the drained words.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1, p, g, e);
            checks++; if (g !== e || g === 16'hBEEF) begin failures++; $display("FAIL refused_drain[%0d] got=%h exp=%h", i, g, e); end
        end
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000) begin failures++; $display("FAIL refused_empty valid=%b data=%h exp valid=0 data=0000", out_valid, out_data); end
    endtask

    task automatic test_drain_wrap();
        logic p; logic [WIDTH-1:0] g, e;
        int npop = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(i < 6, WIDTH'(i + 1), 1'b1, p, g, e);
            if (p) begin
                npop++;
                checks++; if (g !== WIDTH'(npop)) begin failures++; $display("FAIL wrap_order[%0d] got=%h exp=%h", npop, g, WIDTH'(npop)); end
            end
        end
        checks++; if (npop !== 6) begin failures++; $display("FAIL wrap_pop_count got=%0d exp=6", npop); end
        checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1) begin failures++; $display("FAIL wrap_end valid=%b data=%h ready=%b exp 0/0000/1", out_valid, out_data, in_ready); end
`ifdef PE_FIFO_COUNT_EN
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL wrap_count got=%0d exp=0", count); end
`endif
    endtask

    task automatic test_empty_simul();
        logic p; logic [WIDTH-1:0] g, e;
        cycle(1'b1, 16'h0A5A, 1'b1, p, g, e);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL empty_simul_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 16'h0A5A) begin failures++; $display("FAIL empty_simul_data got=%h exp=0a5a", out_data); end
`ifdef PE_FIFO_COUNT_EN
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL empty_simul_count got=%0d exp=1", count); end
`endif
        cycle(1'b0, '0, 1'b1, p, g, e);
        checks++; if (g !== e) begin failures++; $display("FAIL empty_simul_pop got=%h exp=%h", g, e); end
    endtask

    task automatic test_async_reset();
        logic p; logic [WIDTH-1:0] g, e;
        for (int i = 0; i < 3; i++) cycle(1'b1, WIDTH'(16'h0100 + i), 1'b0, p, g, e);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0000) begin failures++; $display("FAIL async_reset ready=%b valid=%b data=%h exp 1/0/0000", in_ready, out_valid, out_data); end
`ifdef PE_FIFO_COUNT_EN
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL async_reset_count got=%0d exp=0", count); end
`endif
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1'b1, 16'h1234, 1'b0, p, g, e);
        checks++; if (out_data !== 16'h1234) begin failures++; $display("FAIL async_head got=%h exp=1234", out_data); end
        cycle(1'b0, '0, 1'b1, p, g, e);
        checks++; if (g !== 16'h1234 || out_valid !== 1'b0) begin failures++; $display("FAIL async_alone got=%h valid=%b exp 1234/0", g, out_valid); end
    endtask

    task automatic test_back_to_back();
        logic p; logic [WIDTH-1:0] g, e;
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)), p, g, e);
            if (p) begin
                checks++; if (g !== e) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, g, e); end
            end
            checks++; if (in_ready !== (q.size() < DEPTH) || out_valid !== (q.size() > 0)) begin failures++; $display("FAIL b2b_flags[%0d] ready=%b valid=%b occ=%0d", i, in_ready, out_valid, q.size()); end
`ifdef PE_FIFO_COUNT_EN
            checks++; if (count !== 3'(q.size())) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", i, count, q.size()); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_full_refused();
        test_drain_wrap();
        test_empty_simul();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
